// File: rtl/rgb2lab_scheduler_if.sv
// Handshake and datapath bundle for rgb2lab_scheduler.
// The scheduler takes the slave side; requesters/consumer/datapath the master.
interface rgb2lab_scheduler_if;
  logic        i_start;
  logic        i_src_valid;
  logic [23:0] i_src_rgb;
  logic        o_src_ready;
  logic        i_tgt_valid;
  logic [23:0] i_tgt_rgb;
  logic        o_tgt_ready;
  logic [7:0]  o_R;
  logic [7:0]  o_G;
  logic [7:0]  o_B;
  logic [15:0] i_l;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        o_lab_valid;
  logic        i_lab_ready;
  logic        o_lab_tag;
  logic [15:0] o_lab_l;
  logic [15:0] o_lab_a;
  logic [15:0] o_lab_b;
  logic        o_busy;
  logic        o_done;

  modport slave (
    input  i_start,
    input  i_src_valid, i_src_rgb,
    output o_src_ready,
    input  i_tgt_valid, i_tgt_rgb,
    output o_tgt_ready,
    output o_R, o_G, o_B,
    input  i_l, i_a, i_b,
    output o_lab_valid,
    input  i_lab_ready,
    output o_lab_tag, o_lab_l, o_lab_a, o_lab_b,
    output o_busy, o_done
  );

  modport master (
    output i_start,
    output i_src_valid, i_src_rgb,
    input  o_src_ready,
    output i_tgt_valid, i_tgt_rgb,
    input  o_tgt_ready,
    input  o_R, o_G, o_B,
    output i_l, i_a, i_b,
    input  o_lab_valid,
    output i_lab_ready,
    input  o_lab_tag, o_lab_l, o_lab_a, o_lab_b,
    input  o_busy, o_done
  );
endinterface

// File: rtl/rgb2lab_scheduler.sv
// Round-robin scheduler sharing one RGB->lab datapath between
// source/target requesters, with tagged result FIFO.
module rgb2lab_scheduler #(
  parameter int LAT        = 2,
  parameter int FRAME_PIX  = 76800,
  parameter int FIFO_DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  rgb2lab_scheduler_if.slave bus
);
  localparam int CW = $clog2(FRAME_PIX + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 2;
  localparam logic [CW-1:0] FRAME = CW'(FRAME_PIX);
  localparam logic [OW-1:0] DEPTH = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] src_cnt;
  logic [CW-1:0] tgt_cnt;
  logic          rr;
  logic          busy;
  logic          done;
  logic [OW-1:0] inflight;
  logic [OW-1:0] fcnt;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LAT-1:0] sr_vld;
  logic [LAT-1:0] sr_tag;
  logic [48:0]   mem [FIFO_DEPTH];
  logic [48:0]   head;
  logic [7:0]    r_q, g_q, b_q;

  logic credit, src_elig, tgt_elig;
  logic src_go, tgt_go, xfer;
  logic push, pop;

  assign credit   = (inflight + fcnt) < DEPTH;
  assign src_elig = (state == RUN) & credit
                  & (src_cnt < FRAME) & bus.i_src_valid;
  assign tgt_elig = (state == RUN) & credit
                  & (tgt_cnt < FRAME) & bus.i_tgt_valid;
  // rr=0 favours source when both contend
  assign src_go = src_elig & (~tgt_elig | ~rr);
  assign tgt_go = tgt_elig & (~src_elig | rr);
  assign xfer   = src_go | tgt_go;

  assign push = sr_vld[LAT-1];
  assign pop  = (fcnt != '0) & bus.i_lab_ready;
  assign head = mem[rptr];

  assign bus.o_src_ready = src_go;
  assign bus.o_tgt_ready = tgt_go;
  assign bus.o_R         = r_q;
  assign bus.o_G         = g_q;
  assign bus.o_B         = b_q;
  assign bus.o_lab_valid = (fcnt != '0);
  assign bus.o_lab_tag   = head[48];
  assign bus.o_lab_l     = head[47:32];
  assign bus.o_lab_a     = head[31:16];
  assign bus.o_lab_b     = head[15:0];
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (xfer) begin
      {r_q, g_q, b_q} <= tgt_go ? bus.i_tgt_rgb : bus.i_src_rgb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_vld   <= '0;
      sr_tag   <= '0;
      inflight <= '0;
    end else begin
      sr_vld[0] <= xfer;
      sr_tag[0] <= tgt_go;
      for (int i = 1; i < LAT; i++) begin
        sr_vld[i] <= sr_vld[i-1];
        sr_tag[i] <= sr_tag[i-1];
      end
      inflight <= inflight + OW'(xfer) - OW'(push);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {sr_tag[LAT-1], bus.i_l, bus.i_a, bus.i_b};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      fcnt <= fcnt + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      src_cnt <= '0;
      tgt_cnt <= '0;
      rr      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (src_go) src_cnt <= src_cnt + CW'(1);
      if (tgt_go) tgt_cnt <= tgt_cnt + CW'(1);
      if (src_elig & tgt_elig) rr <= ~rr;
      unique case (state)
        IDLE: if (bus.i_start) begin
          state   <= RUN;
          src_cnt <= '0;
          tgt_cnt <= '0;
          rr      <= 1'b0;
          busy    <= 1'b1;
        end
        RUN: if (src_cnt == FRAME && tgt_cnt == FRAME)
          state <= DRAIN;
        DRAIN: if (inflight == '0 && fcnt == '0) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rgb2lab_scheduler.sv
// Directed bench for rgb2lab_scheduler (FRAME_PIX=4, LAT=2, FIFO_DEPTH=4).
// Datapath model: one register after o_R/G/B, so results land LAT cycles on.
module tb_rgb2lab_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rgb2lab_scheduler_if bus();

  rgb2lab_scheduler #(
    .LAT(2), .FRAME_PIX(4), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  logic [23:0] dp = '0;
  always @(posedge clk) dp <= {bus.o_R, bus.o_G, bus.o_B};
  assign bus.i_l = {dp[23:16], 8'h00};
  assign bus.i_a = {dp[15:8], 8'h00};
  assign bus.i_b = {dp[7:0], 8'h00};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        src_fire = 1'b0;
  logic        tgt_fire = 1'b0;
  logic [23:0] src_q[$];
  logic [23:0] tgt_q[$];
  logic        acc_tag[$];
  int          acc_cyc[$];
  logic        pop_tag[$];
  logic [47:0] pop_d[$];
  int          pop_cyc[$];
  int          first_valid = -1;
  int          done_n = 0;
  int          done_cyc = -1;

  always @(negedge clk) begin
    src_fire = !rst && bus.i_src_valid && bus.o_src_ready;
    tgt_fire = !rst && bus.i_tgt_valid && bus.o_tgt_ready;
    if (src_fire) begin acc_tag.push_back(1'b0); acc_cyc.push_back(cyc); end
    if (tgt_fire) begin acc_tag.push_back(1'b1); acc_cyc.push_back(cyc); end
    if (!rst && bus.o_lab_valid && bus.i_lab_ready) begin
      pop_tag.push_back(bus.o_lab_tag);
      pop_d.push_back({bus.o_lab_l, bus.o_lab_a, bus.o_lab_b});
      pop_cyc.push_back(cyc);
    end
    if (!rst && bus.o_lab_valid && first_valid < 0) first_valid = cyc;
    if (!rst && bus.o_done) begin done_n++; done_cyc = cyc; end
  end

  always @(posedge clk) begin
    cyc++;
    #2;
    if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
    if (tgt_fire && tgt_q.size() > 0) void'(tgt_q.pop_front());
    bus.i_src_valid = src_q.size() > 0;
    bus.i_src_rgb   = (src_q.size() > 0) ? src_q[0] : 24'h0;
    bus.i_tgt_valid = tgt_q.size() > 0;
    bus.i_tgt_rgb   = (tgt_q.size() > 0) ? tgt_q[0] : 24'h0;
  end

  function automatic logic [47:0] lab_of(logic [23:0] p);
    return {p[23:16], 8'h00, p[15:8], 8'h00, p[7:0], 8'h00};
  endfunction

  task automatic clear_logs();
    acc_tag.delete(); acc_cyc.delete();
    pop_tag.delete(); pop_d.delete(); pop_cyc.delete();
    first_valid = -1; done_n = 0; done_cyc = -1;
  endtask

  task automatic do_reset(int n);
    @(posedge clk); #1;
    rst = 1'b1;
    src_q.delete(); tgt_q.delete();
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.i_start = 1'b1;
    @(posedge clk); #1 bus.i_start = 1'b0;
  endtask

  task automatic wait_done(int limit);
    for (int i = 0; i < limit && done_n == 0; i++) begin
      @(negedge clk); #1;
    end
  endtask

  function automatic logic [7:0] tag_vec(logic q[$]);
    logic [7:0] v = '0;
    for (int i = 0; i < 8 && i < q.size(); i++) v[i] = q[i];
    return v;
  endfunction

  task automatic test_reset();
    bus.i_lab_ready = 1'b0;
    do_reset(2);
    src_q.push_back(24'h123456);
    tgt_q.push_back(24'h654321);
    @(negedge clk); #1;
    checks++; if (bus.o_R !== 8'h0) begin errors++; $display("FAIL reset_o_R got=%h exp=0", bus.o_R); end
    checks++; if (bus.o_G !== 8'h0) begin errors++; $display("FAIL reset_o_G got=%h exp=0", bus.o_G); end
    checks++; if (bus.o_B !== 8'h0) begin errors++; $display("FAIL reset_o_B got=%h exp=0", bus.o_B); end
    checks++; if (bus.o_lab_valid !== 1'b0) begin errors++; $display("FAIL reset_lab_valid got=%b exp=0", bus.o_lab_valid); end
    checks++; if (bus.o_lab_tag !== 1'b0) begin errors++; $display("FAIL reset_lab_tag got=%b exp=0", bus.o_lab_tag); end
    checks++; if (bus.o_lab_l !== 16'h0) begin errors++; $display("FAIL reset_lab_l got=%h exp=0", bus.o_lab_l); end
    checks++; if (bus.o_lab_a !== 16'h0) begin errors++; $display("FAIL reset_lab_a got=%h exp=0", bus.o_lab_a); end
    checks++; if (bus.o_lab_b !== 16'h0) begin errors++; $display("FAIL reset_lab_b got=%h exp=0", bus.o_lab_b); end
    checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready got=%b exp=0", bus.o_src_ready); end
    checks++; if (bus.o_tgt_ready !== 1'b0) begin errors++; $display("FAIL reset_tgt_ready got=%b exp=0", bus.o_tgt_ready); end
  endtask

  task automatic test_source_only();
    int c0, c3;
    logic [47:0] d0, d3;
    logic t0;
    do_reset(1);
    bus.i_lab_ready = 1'b1;
    pulse_start();
    src_q.push_back(24'h102030); src_q.push_back(24'h405060);
    src_q.push_back(24'h708090); src_q.push_back(24'hA0B0C0);
    repeat (15) @(negedge clk);
    #1;
    c0 = (acc_cyc.size() > 0) ? acc_cyc[0] : -100;
    c3 = (acc_cyc.size() > 3) ? acc_cyc[3] : -100;
    d0 = (pop_d.size() > 0) ? pop_d[0] : 48'hx;
    d3 = (pop_d.size() > 3) ? pop_d[3] : 48'hx;
    t0 = (pop_tag.size() > 0) ? pop_tag[0] : 1'bx;
    checks++; if (acc_tag.size() !== 4) begin errors++; $display("FAIL src_accepts got=%0d exp=4", acc_tag.size()); end
    checks++; if (c3 - c0 !== 3) begin errors++; $display("FAIL src_rate got=%0d exp=3", c3 - c0); end
    checks++; if (first_valid !== c0 + 3) begin errors++; $display("FAIL src_latency got=%0d exp=%0d", first_valid, c0 + 3); end
    checks++; if (pop_d.size() !== 4) begin errors++; $display("FAIL src_pops got=%0d exp=4", pop_d.size()); end
    checks++; if (t0 !== 1'b0) begin errors++; $display("FAIL src_tag0 got=%b exp=0", t0); end
    checks++; if (d0 !== 48'h1000_2000_3000) begin errors++; $display("FAIL src_lab0 got=%h exp=100020003000", d0); end
    checks++; if (d3 !== 48'hA000_B000_C000) begin errors++; $display("FAIL src_lab3 got=%h exp=a000b000c000", d3); end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL src_no_done got=%0d exp=0", done_n); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL src_busy got=%b exp=1", bus.o_busy); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_px[8];
    int lastp;
    exp_px = '{24'h010203, 24'h818283, 24'h111213, 24'h919293,
               24'h212223, 24'hA1A2A3, 24'h313233, 24'hB1B2B3};
    do_reset(1);
    bus.i_lab_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(exp_px[2*i]);
      tgt_q.push_back(exp_px[2*i+1]);
    end
    wait_done(60);
    lastp = (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size()-1] : -100;
    checks++; if (tag_vec(acc_tag) !== 8'hAA) begin errors++; $display("FAIL b2b_grants got=%h exp=aa", tag_vec(acc_tag)); end
    checks++; if (acc_cyc.size() != 8 || acc_cyc[7] - acc_cyc[0] != 7) begin errors++; $display("FAIL b2b_rate got_n=%0d exp=8 consecutive", acc_cyc.size()); end
    checks++; if (tag_vec(pop_tag) !== 8'hAA) begin errors++; $display("FAIL b2b_out_tags got=%h exp=aa", tag_vec(pop_tag)); end
    checks++; if (pop_d.size() !== 8) begin errors++; $display("FAIL b2b_pops got=%0d exp=8", pop_d.size()); end
    for (int i = 0; i < 8 && i < pop_d.size(); i++) begin
      checks++; if (pop_d[i] !== lab_of(exp_px[i])) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, pop_d[i], lab_of(exp_px[i])); end
    end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL b2b_done_count got=%0d exp=1", done_n); end
    checks++; if (done_cyc !== lastp + 2) begin errors++; $display("FAIL b2b_done_time got=%0d exp=%0d", done_cyc, lastp + 2); end
    @(negedge clk); #1;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall got=%b exp=0", bus.o_busy); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL b2b_done_once got=%0d exp=1", done_n); end
  endtask

  task automatic test_backpressure();
    logic [23:0] exp_px[8];
    exp_px = '{24'h0A0B0C, 24'hC0C1C2, 24'h1A1B1C, 24'hD0D1D2,
               24'h2A2B2C, 24'hE0E1E2, 24'h3A3B3C, 24'hF0F1F2};
    do_reset(1);
    bus.i_lab_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(exp_px[2*i]);
      tgt_q.push_back(exp_px[2*i+1]);
    end
    repeat (12) @(negedge clk);
    #1;
    checks++; if (acc_tag.size() !== 4) begin errors++; $display("FAIL bp_accepts got=%0d exp=4", acc_tag.size()); end
    checks++; if (bus.o_src_ready !== 1'b0) begin errors++; $display("FAIL bp_src_ready got=%b exp=0", bus.o_src_ready); end
    checks++; if (bus.o_tgt_ready !== 1'b0) begin errors++; $display("FAIL bp_tgt_ready got=%b exp=0", bus.o_tgt_ready); end
    checks++; if (bus.o_lab_valid !== 1'b1) begin errors++; $display("FAIL bp_lab_valid got=%b exp=1", bus.o_lab_valid); end
    checks++; if (pop_d.size() !== 0) begin errors++; $display("FAIL bp_no_pop got=%0d exp=0", pop_d.size()); end
    @(posedge clk); #1 bus.i_lab_ready = 1'b1;
    wait_done(60);
    checks++; if (pop_d.size() !== 8) begin errors++; $display("FAIL bp_pops got=%0d exp=8", pop_d.size()); end
    checks++; if (tag_vec(pop_tag) !== 8'hAA) begin errors++; $display("FAIL bp_out_tags got=%h exp=aa", tag_vec(pop_tag)); end
    for (int i = 0; i < 8 && i < pop_d.size(); i++) begin
      checks++; if (pop_d[i] !== lab_of(exp_px[i])) begin errors++; $display("FAIL bp_data%0d got=%h exp=%h", i, pop_d[i], lab_of(exp_px[i])); end
    end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL bp_done got=%0d exp=1", done_n); end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] exp_px[8];
    int k = 0;
    exp_px = '{24'h445566, 24'h778899, 24'h456789, 24'h987654,
               24'h13579B, 24'h2468AC, 24'hFEDCBA, 24'h0F1E2D};
    do_reset(1);
    bus.i_lab_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(24'hEE0000 | 24'(i));
      tgt_q.push_back(24'hDD0000 | 24'(i));
    end
    do begin @(negedge clk); #1; k++; end while (acc_tag.size() < 3 && k < 30);
    @(posedge clk); #1;
    rst = 1'b1;
    src_q.delete(); tgt_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
    @(negedge clk); #1;
    checks++; if (bus.o_lab_valid !== 1'b0) begin errors++; $display("FAIL mid_lab_valid got=%b exp=0", bus.o_lab_valid); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", bus.o_busy); end
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(exp_px[2*i]);
      tgt_q.push_back(exp_px[2*i+1]);
    end
    wait_done(60);
    checks++; if (pop_d.size() !== 8) begin errors++; $display("FAIL mid_pops got=%0d exp=8", pop_d.size()); end
    for (int i = 0; i < 8 && i < pop_d.size(); i++) begin
      checks++; if (pop_d[i] !== lab_of(exp_px[i])) begin errors++; $display("FAIL mid_data%0d got=%h exp=%h", i, pop_d[i], lab_of(exp_px[i])); end
    end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL mid_done got=%0d exp=1", done_n); end
  endtask

  task automatic test_start_ignored();
    int t4, t7;
    do_reset(1);
    bus.i_lab_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) src_q.push_back(24'h202020 + 24'(i));
    @(posedge clk);
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) tgt_q.push_back(24'h606060 + 24'(i));
    wait_done(60);
    t4 = (acc_cyc.size() > 4) ? acc_cyc[4] : -100;
    t7 = (acc_cyc.size() > 7) ? acc_cyc[7] : -100;
    checks++; if (tag_vec(acc_tag) !== 8'hF0) begin errors++; $display("FAIL ign_grants got=%h exp=f0", tag_vec(acc_tag)); end
    checks++; if (t7 - t4 !== 3) begin errors++; $display("FAIL ign_tgt_rate got=%0d exp=3", t7 - t4); end
    checks++; if (pop_d.size() !== 8) begin errors++; $display("FAIL ign_pops got=%0d exp=8", pop_d.size()); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL ign_done got=%0d exp=1", done_n); end
  endtask

  initial begin
    bus.i_start     = 1'b0;
    bus.i_lab_ready = 1'b0;
    test_reset();
    test_source_only();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb2lab_scheduler.md
# rgb2lab_scheduler

Sequencer and arbiter that time-shares one RGB-to-lαβ conversion datapath between two pixel requesters: the source image (tag 0) and the target image (tag 1) of the colour-transfer flow. The block takes RGB pixels through valid/ready handshakes and drives the datapath inputs from registers. It captures the datapath outputs a fixed latency later and returns tagged lαβ results through a small output FIFO with backpressure. It sits between the frame-buffer readers and the statistics stage, and it signals frame completion.

## Interface
- LAT, 2: cycles from the o_R/o_G/o_B update to valid i_l/i_a/i_b; must be ≥1.
- FRAME_PIX, 76800: pixels per requester per frame. Counters are $clog2(FRAME_PIX+1) bits.
- FIFO_DEPTH, 4: output FIFO entries; power of two.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that starts a frame; honoured only in IDLE.
- i_src_valid / i_src_rgb / o_src_ready  in/in/out  1/24/1  source pixel handshake, with R in [23:16], G in [15:8], B in [7:0].
- i_tgt_valid / i_tgt_rgb / o_tgt_ready  in/in/out  1/24/1  target pixel handshake, same packing.
- o_R, o_G, o_B  out  8 each  registered datapath inputs.
- i_l, i_a, i_b  in  16 each  datapath outputs, 3.13 fixed point.
- o_lab_valid  out  1  FIFO not empty.
- i_lab_ready  in  1  consumer accepts the head entry.
- o_lab_tag  out  1  0 = source, 1 = target.
- o_lab_l, o_lab_a, o_lab_b  out  16 each  head entry.
- o_busy  out  1  high whenever the state is not IDLE.
- o_done  out  1  one-cycle pulse at frame end.

## Operation
- States and transitions:
  - IDLE: i_start moves to RUN and clears both pixel counters and the round-robin pointer (pointer set to src).
  - RUN: when both counters equal FRAME_PIX, move to DRAIN.
  - DRAIN: when the in-flight count is 0 and the FIFO is empty, move to DONE.
  - DONE: asserts o_done for one cycle, then returns to IDLE.
- Issue credit: credit = (inflight + fifo_count < FIFO_DEPTH). The count does not subtract a same-cycle pop.
- Eligibility: a requester is eligible when the state is RUN, credit is true, its counter is below FRAME_PIX, and its valid is high.
- Grant (combinational ready):
  - Only one requester eligible: grant it.
  - Both eligible: grant the one the pointer selects, then move the pointer to the other requester.
  - Ready never depends on the requester's own valid beyond this eligibility rule.
- Transfer: valid & ready at a clock edge.
  - o_R/o_G/o_B load the pixel; otherwise they hold their value.
  - The counter for that requester increments.
  - The pixel's valid bit and tag enter a LAT-deep shift register.
- Capture: when the shift-register output valid is 1, {tag, i_l, i_a, i_b} is written into the FIFO.
- FIFO: push and pop in the same cycle is allowed. Overflow is impossible by construction. Order within each tag follows acceptance order.
- Pop: o_lab_valid & i_lab_ready.
- i_start outside IDLE is ignored.
- Reset:
  - State goes to IDLE.
  - Counters, inflight, FIFO pointers, shift register, and pointer are cleared.
  - o_R/G/B, o_lab_* and o_done are 0; ready signals and o_busy are low.
  - In-flight results are discarded, including mid-frame.

## Timing
- A pixel accepted in cycle k:
  - appears on o_R/G/B in cycle k+1;
  - its datapath result is sampled at the end of cycle k+LAT;
  - o_lab_valid rises in cycle k+LAT+1 if the FIFO was empty.
- Throughput is 1 pixel/cycle, sustained while i_lab_ready stays high.
- With i_lab_ready low, at most FIFO_DEPTH pixels are accepted before both readies drop.
- o_busy rises the cycle after i_start and falls the cycle after o_done.
- Reset takes effect at the clock edge where i_rst is sampled high.

## Test plan
- Datapath model: i_l = {o_R, 8'h00}, i_a = {o_G, 8'h00}, i_b = {o_B, 8'h00}, delayed LAT cycles. Bench uses FRAME_PIX=4, LAT=2, FIFO_DEPTH=4.
- Reset: hold i_rst 2 cycles → every output is 0, o_busy=0, ready signals low.
- Source only: i_start, then src valid with RGB 0x102030, 0x405060, 0x708090, 0xA0B0C0 and i_lab_ready=1.
  - Expect one accept per cycle and first o_lab_valid 3 cycles after the first accept: tag 0, l=0x1000, a=0x2000, b=0x3000.
  - Tgt valid is never asserted, so the frame waits in RUN and o_done does not fire.
- Both streams valid continuously: grants alternate src, tgt, src, tgt for 8 accepts; output tags are 0,1,0,1,0,1,0,1; o_done pulses once after the last pop.
- Backpressure: i_lab_ready=0 with both valid → exactly 4 accepts, then both readies stay 0. Raising i_lab_ready releases all 8 results in order with no loss or duplication.
- Reset mid-frame: after 3 accepts, pulse i_rst for 1 cycle → o_lab_valid=0 in the next cycle and no stale result ever emerges. A fresh i_start begins with counters at 0.
- i_start pulsed during RUN is ignored. Once the source finishes its 4 pixels, the target is granted every cycle.
